// File: rtl/udptxarb_pkg.sv
// rtl/udptxarb_pkg.sv - shared types and helpers for the UDP tx arbiter
package udptxarb_pkg;

  localparam int LENW = 16;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CHECK = 5'b00010,
    START = 5'b00100,
    XFER  = 5'b01000,
    GAP   = 5'b10000
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/udptxarb_rrpick.sv
// rtl/udptxarb_rrpick.sv - combinational round-robin picker
// Picks the first set request searching upward from ptr+1 with wraparound.
module rrpick
  import udptxarb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IDXW-1:0] idx_o
);

  localparam int EXTW = 1 << IDXW;

  logic [EXTW-1:0] req_ext;
  int              j;

  always_comb begin
    req_ext              = '0;
    req_ext[NREQ-1:0]    = req_i;
    valid_o              = 1'b0;
    idx_o                = '0;
    j                    = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (req_ext[IDXW'(j)]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/udptxarb.sv
// rtl/udptxarb.sv - round-robin arbiter for the shared UDP transmit path
// One packet per grant, inter-packet gap, and a dv timeout so no handler can hold the link.
module udptxarb
  import udptxarb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXLEN  = 1472,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [LENW*NREQ-1:0] len_i,
  input  logic [NREQ-1:0]      dv_i,
  input  logic [8*NREQ-1:0]    data_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      abort_o,
  output logic                 tx_req_o,
  output logic [LENW-1:0]      tx_len_o,
  input  logic                 tx_ack_i,
  output logic                 tx_dv_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_last_o,
  output logic [15:0]          droperr_o
);

  localparam int IDXW = clog2(NREQ);
  localparam int GAPW = clog2(IFG + 1);
  localparam int TOW  = clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [TOW-1:0]  to_q, to_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [15:0]     droperr_q;
  logic            drop_inc;

  logic            pick_v;
  logic [IDXW-1:0] pick_idx;
  logic            lane_dv;
  logic [7:0]      lane_data;

  rrpick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  assign lane_dv   = dv_i[idx_q];
  assign lane_data = data_i[{idx_q, 3'b000} +: 8];
  assign droperr_o = droperr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= IDXW'(NREQ - 1);
      len_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      droperr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      if (drop_inc && droperr_q != 16'hffff) droperr_q <= droperr_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    to_d      = to_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    drop_inc  = 1'b0;
    grant_o   = '0;
    done_o    = '0;
    abort_o   = '0;
    tx_req_o  = 1'b0;
    tx_len_o  = '0;
    tx_dv_o   = 1'b0;
    tx_data_o = '0;
    tx_last_o = 1'b0;

    // End-of-transfer and timeout pulses land in the first GAP cycle.
    if (done_q)  done_o[idx_q]  = 1'b1;
    if (abort_q) abort_o[idx_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          len_d   = len_i[{pick_idx, 4'b0000} +: LENW];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (len_q == '0) begin
          done_o[idx_q] = 1'b1;
          gap_d         = '0;
          state_d       = GAP;
        end else if (len_q > LENW'(MAXLEN)) begin
          abort_o[idx_q] = 1'b1;
          drop_inc       = 1'b1;
          gap_d          = '0;
          state_d        = GAP;
        end else begin
          state_d = START;
        end
      end
      START: begin
        tx_req_o = 1'b1;
        tx_len_o = len_q;
        if (tx_ack_i) begin
          cnt_d   = len_q;
          to_d    = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        grant_o[idx_q] = 1'b1;
        tx_len_o       = len_q;
        if (lane_dv) begin
          tx_dv_o   = 1'b1;
          tx_data_o = lane_data;
          to_d      = '0;
          cnt_d     = cnt_q - LENW'(1);
          if (cnt_q == LENW'(1)) begin
            tx_last_o = 1'b1;
            done_d    = 1'b1;
            gap_d     = '0;
            state_d   = GAP;
          end
        end else if (to_q == TOW'(TIMEOUT - 1)) begin
          abort_d  = 1'b1;
          drop_inc = 1'b1;
          gap_d    = '0;
          state_d  = GAP;
        end else begin
          to_d = to_q + TOW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAPW'(IFG - 1)) state_d = IDLE;
        else                         gap_d   = gap_q + GAPW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
